prog_loader: RTL and testbench

Synthesizable boot loader that sits directly upstream of single_cycle_top. It replaces the simulation-only hex preload of instruction memory.
- Receives a byte stream (from a UART RX or a bench driver) framed as: word count, program words, checksum.
- Writes the program words into IMEM through a dedicated write port.
- Holds the core in reset until the load completes and the checksum matches.

---
 rtl/loader_pkg.sv | 20 ++
 rtl/byte_packer.sv | 44 ++++
 rtl/prog_loader.sv | 144 ++++++++++++++
 tb/tb_prog_loader.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/loader_pkg.sv
// Shared types and constants for the program loader.
package loader_pkg;

  // ST_IDLE only exists for the single cycle after reset release.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_DATA,
    ST_CSUM,
    ST_DONE,
    ST_ERROR
  } state_t;

  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_LEN  = 2'b01;
  localparam logic [1:0] ERR_CSUM = 2'b10;

  localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/byte_packer.sv
// Assembles accepted bytes into little-endian 32-bit words.
// word_valid/word are combinational on the cycle the 4th byte is accepted,
// so the consumer acts on the same edge that takes the last byte.
module byte_packer
  import loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        enable,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        word_valid,
  output logic [31:0] word
);

  logic [1:0]  cnt;
  logic [23:0] low_bytes;
  logic        accept;

  assign accept     = in_valid && enable;
  assign word_valid = accept && (cnt == 2'(BYTES_PER_WORD - 1));
  assign word       = {in_data, low_bytes};

  // Byte counter and storage for the first three bytes of a word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= 2'd0;
      low_bytes <= 24'd0;
    end else if (clear) begin
      cnt       <= 2'd0;
      low_bytes <= 24'd0;
    end else if (accept) begin
      cnt <= cnt + 2'd1;
      case (cnt)
        2'd0:    low_bytes[7:0]   <= in_data;
        2'd1:    low_bytes[15:8]  <= in_data;
        2'd2:    low_bytes[23:16] <= in_data;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/prog_loader.sv
// Boot loader: receives length/words/checksum over a byte stream, writes
// the words into IMEM and releases the core reset only on a good checksum.
//
// state    | meaning
// ST_IDLE  | first cycle after reset release, nothing accepted
// ST_HDR   | collecting the 32-bit word count
// ST_DATA  | collecting program words, one IMEM write per word
// ST_CSUM  | collecting the checksum word
// ST_DONE  | load good, core released
// ST_ERROR | load aborted, core held in reset
module prog_loader
  import loader_pkg::*;
#(
  parameter int IMEM_DEPTH = 1024,
  parameter int START_ADDR = 0,
  localparam int ADDR_W = $clog2(IMEM_DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  input  logic              reload,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              core_rst_n,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [1:0]        err_code,
  output logic [ADDR_W:0]   words_loaded
);

  localparam logic [31:0] CAPACITY = 32'(IMEM_DEPTH - START_ADDR);

  state_t        state;
  logic [31:0]   len;
  logic [31:0]   sum;
  logic          word_valid;
  logic [31:0]   word;
  logic          restart;
  logic [ADDR_W:0] wl_next;
  logic          last_word;

  assign restart   = reload && ((state == ST_DONE) || (state == ST_ERROR));
  assign wl_next   = words_loaded + 1'b1;
  assign last_word = (32'(wl_next) == len);

  byte_packer u_packer (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (restart),
    .enable     (in_ready),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .word_valid (word_valid),
    .word       (word)
  );

  // Load sequencer with registered status, handshake and IMEM write port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      len          <= 32'd0;
      sum          <= 32'd0;
      in_ready     <= 1'b0;
      imem_we      <= 1'b0;
      imem_addr    <= '0;
      imem_wdata   <= 32'd0;
      core_rst_n   <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
      err_code     <= ERR_NONE;
      words_loaded <= '0;
    end else begin
      imem_we <= 1'b0;
      case (state)
        ST_IDLE: begin
          state    <= ST_HDR;
          in_ready <= 1'b1;
          busy     <= 1'b1;
        end
        ST_HDR: begin
          if (word_valid) begin
            len <= word;
            sum <= 32'd0;
            if (word > CAPACITY) begin
              state    <= ST_ERROR;
              err      <= 1'b1;
              err_code <= ERR_LEN;
              busy     <= 1'b0;
              in_ready <= 1'b0;
            end else if (word == 32'd0) begin
              state <= ST_CSUM;
            end else begin
              state <= ST_DATA;
            end
          end
        end
        ST_DATA: begin
          if (word_valid) begin
            imem_we      <= 1'b1;
            imem_addr    <= ADDR_W'(START_ADDR) + words_loaded[ADDR_W-1:0];
            imem_wdata   <= word;
            words_loaded <= wl_next;
            sum          <= sum + word;
            if (last_word) state <= ST_CSUM;
          end
        end
        ST_CSUM: begin
          if (word_valid) begin
            busy     <= 1'b0;
            in_ready <= 1'b0;
            if (word == sum) begin
              state      <= ST_DONE;
              done       <= 1'b1;
              core_rst_n <= 1'b1;
            end else begin
              state    <= ST_ERROR;
              err      <= 1'b1;
              err_code <= ERR_CSUM;
            end
          end
        end
        ST_DONE, ST_ERROR: begin
          if (reload) begin
            state        <= ST_HDR;
            in_ready     <= 1'b1;
            busy         <= 1'b1;
            done         <= 1'b0;
            err          <= 1'b0;
            err_code     <= ERR_NONE;
            core_rst_n   <= 1'b0;
            words_loaded <= '0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: a byte-list reference model decides
// every output from the bytes accepted so far; literal checks pin key results.
module tb_prog_loader;

  localparam int DEPTH  = 1024;
  localparam int ADDR_W = 10;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic [7:0]        in_data = 8'd0;
  logic              reload = 1'b0;
  logic              in_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              core_rst_n;
  logic              busy;
  logic              done;
  logic              err;
  logic [1:0]        err_code;
  logic [ADDR_W:0]   words_loaded;

  always #5 clk = ~clk;

  prog_loader #(.IMEM_DEPTH(DEPTH), .START_ADDR(0)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .reload       (reload),
    .imem_we      (imem_we),
    .imem_addr    (imem_addr),
    .imem_wdata   (imem_wdata),
    .core_rst_n   (core_rst_n),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .err_code     (err_code),
    .words_loaded (words_loaded)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0]        mbytes[$];
  bit                m_started = 1'b0;
  logic              m_in_ready = 1'b0, m_busy = 1'b0, m_done = 1'b0, m_err = 1'b0;
  logic              m_core = 1'b0, m_we = 1'b0;
  logic [1:0]        m_code = 2'b00;
  logic [ADDR_W:0]   m_wl = '0;
  logic [ADDR_W-1:0] m_addr = '0;
  logic [31:0]       m_wdata = 32'd0;

  function automatic logic [31:0] mword(input int k);
    return {mbytes[4*k+3], mbytes[4*k+2], mbytes[4*k+1], mbytes[4*k]};
  endfunction

  // Outcome is a pure function of the bytes accepted since the load started.
  task automatic model_eval();
    int n, k;
    logic [31:0] len, w, s;
    n = mbytes.size();
    if (n % 4 != 0) return;
    k   = n / 4;
    w   = mword(k - 1);
    len = mword(0);
    if (k == 1) begin
      if (len > 32'(DEPTH)) begin
        m_err = 1'b1; m_code = 2'b01; m_busy = 1'b0; m_in_ready = 1'b0;
      end
    end else if (32'(k - 1) <= len) begin
      m_we = 1'b1; m_addr = ADDR_W'(k - 2); m_wdata = w; m_wl = 11'(k - 1);
    end else begin
      s = 32'd0;
      for (int i = 1; i <= int'(len); i++) s = s + mword(i);
      m_busy = 1'b0; m_in_ready = 1'b0;
      if (w == s) begin
        m_done = 1'b1; m_core = 1'b1;
      end else begin
        m_err = 1'b1; m_code = 2'b10;
      end
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_started = 1'b0; mbytes.delete();
      m_in_ready = 1'b0; m_busy = 1'b0; m_done = 1'b0; m_err = 1'b0;
      m_code = 2'b00; m_core = 1'b0; m_wl = '0; m_we = 1'b0;
      m_addr = '0; m_wdata = 32'd0;
    end else begin
      m_we = 1'b0;
      if (!m_started) begin
        m_started = 1'b1; m_in_ready = 1'b1; m_busy = 1'b1;
      end else if ((m_done || m_err) && reload) begin
        mbytes.delete();
        m_wl = '0; m_done = 1'b0; m_err = 1'b0; m_code = 2'b00; m_core = 1'b0;
        m_in_ready = 1'b1; m_busy = 1'b1;
      end else if (m_in_ready && in_valid) begin
        mbytes.push_back(in_data);
        model_eval();
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  logic [ADDR_W-1:0] seen_addr[$];
  logic [31:0]       seen_data[$];

  always @(negedge clk) begin
    chk("in_ready", 64'(in_ready), 64'(m_in_ready));
    chk("busy", 64'(busy), 64'(m_busy));
    chk("done", 64'(done), 64'(m_done));
    chk("err", 64'(err), 64'(m_err));
    chk("err_code", 64'(err_code), 64'(m_code));
    chk("core_rst_n", 64'(core_rst_n), 64'(m_core));
    chk("words_loaded", 64'(words_loaded), 64'(m_wl));
    chk("imem_we", 64'(imem_we), 64'(m_we));
    if (m_we) begin
      chk("imem_addr", 64'(imem_addr), 64'(m_addr));
      chk("imem_wdata", 64'(imem_wdata), 64'(m_wdata));
    end
    if (imem_we) begin
      seen_addr.push_back(imem_addr);
      seen_data.push_back(imem_wdata);
    end
  end

  // ---------------- stimulus ----------------
  logic [7:0]  frame[$];
  logic [31:0] s1w[3] = '{32'h00500093, 32'h00700113, 32'h002081B3};

  task automatic push_w(input logic [31:0] w);
    frame.push_back(w[7:0]);
    frame.push_back(w[15:8]);
    frame.push_back(w[23:16]);
    frame.push_back(w[31:24]);
  endtask

  task automatic build_s1(input logic [31:0] csum);
    frame.delete();
    push_w(32'd3);
    for (int i = 0; i < 3; i++) push_w(s1w[i]);
    push_w(csum);
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int waitc;
    repeat (gap) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    waitc = 0;
    while (!in_ready && waitc < 40) begin
      @(negedge clk);
      waitc++;
    end
    chk("byte_accepted", 64'(in_ready), 64'd1);
  endtask

  task automatic send_frame(input int mode);
    int gap;
    for (int i = 0; i < frame.size(); i++) begin
      if (mode == 0) gap = 0;
      else gap = (i % 2 == 1) ? 1 : int'($urandom_range(0, 3));
      send_byte(frame[i], gap);
    end
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic do_reload();
    @(negedge clk);
    reload = 1'b1;
    @(negedge clk);
    reload = 1'b0;
    chk("reload_core_rst_n", 64'(core_rst_n), 64'd0);
    chk("reload_busy", 64'(busy), 64'd1);
    seen_addr.delete();
    seen_data.delete();
  endtask

  task automatic check_s1_writes();
    chk("s1_write_count", 64'(seen_addr.size()), 64'd3);
    for (int i = 0; i < 3 && i < seen_addr.size(); i++) begin
      chk("s1_addr", 64'(seen_addr[i]), 64'(i));
      chk("s1_data", 64'(seen_data[i]), 64'(s1w[i]));
    end
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] rw[$];
    logic [31:0] rsum;
    int rl;

    repeat (3) @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_core_rst_n", 64'(core_rst_n), 64'd0);
    chk("rst_imem_wdata", 64'(imem_wdata), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("hdr_in_ready", 64'(in_ready), 64'd1);

    // good load
    build_s1(32'h00E08359);
    send_frame(0);
    check_s1_writes();
    chk("s1_done", 64'(done), 64'd1);
    chk("s1_core", 64'(core_rst_n), 64'd1);
    chk("s1_wl", 64'(words_loaded), 64'd3);

    // bad checksum
    do_reload();
    build_s1(32'h00E0835A);
    send_frame(0);
    check_s1_writes();
    chk("s2_err", 64'(err), 64'd1);
    chk("s2_code", 64'(err_code), 64'd2);
    chk("s2_core", 64'(core_rst_n), 64'd0);

    // length overflow, with stream still offering bytes afterwards
    do_reload();
    frame.delete();
    push_w(32'd1025);
    push_w(32'hDEADBEEF);
    for (int i = 0; i < 4; i++) send_byte(frame[i], 0);
    for (int i = 4; i < 8; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = frame[i];
    end
    @(negedge clk);
    in_valid = 1'b0;
    chk("ovf_writes", 64'(seen_addr.size()), 64'd0);
    chk("ovf_code", 64'(err_code), 64'd1);
    chk("ovf_in_ready", 64'(in_ready), 64'd0);

    // empty program
    do_reload();
    frame.delete();
    push_w(32'd0);
    push_w(32'd0);
    send_frame(0);
    chk("len0_done", 64'(done), 64'd1);
    chk("len0_wl", 64'(words_loaded), 64'd0);
    chk("len0_writes", 64'(seen_addr.size()), 64'd0);

    // good load with gaps
    do_reload();
    build_s1(32'h00E08359);
    send_frame(1);
    check_s1_writes();
    chk("gap_done", 64'(done), 64'd1);

    // reset in the middle of DATA
    do_reload();
    build_s1(32'h00E08359);
    for (int i = 0; i < 9; i++) send_byte(frame[i], 0);
    @(negedge clk);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_we", 64'(imem_we), 64'd0);
    chk("mid_rst_wl", 64'(words_loaded), 64'd0);
    chk("mid_rst_addr", 64'(imem_addr), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen_addr.delete();
    seen_data.delete();
    @(negedge clk);
    send_frame(0);
    check_s1_writes();
    chk("post_rst_done", 64'(done), 64'd1);

    // reload and random successful load
    do_reload();
    rl = int'($urandom_range(1, 8));
    rw.delete();
    rsum = 32'd0;
    frame.delete();
    push_w(32'(rl));
    for (int i = 0; i < rl; i++) begin
      rw.push_back($urandom());
      rsum = rsum + rw[i];
      push_w(rw[i]);
    end
    push_w(rsum);
    send_frame(1);
    chk("rand_done", 64'(done), 64'd1);
    chk("rand_count", 64'(seen_addr.size()), 64'(rl));
    for (int i = 0; i < rl && i < seen_data.size(); i++)
      chk("rand_data", 64'(seen_data[i]), 64'(rw[i]));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
